edge_event_queue: RTL
=====================

Name: edge_event_queue

Overview:
- Consumes a sticky per-bit negative-edge capture vector produced by the upstream edge-capture stage.
- Converts each newly set bit into a discrete event carrying the bit index. Events are issued lowest index first and buffered in a small FIFO.
- Delivers events to a downstream consumer (interrupt/event handler) over a valid/ready handshake. Each captured bit is reported exactly once per assertion.

Parameters:
- WIDTH, 32, width of the edge vector; must be ≥2.
- DEPTH, 4, event FIFO entries; must be a power of 2, ≥2.
- IDXW (localparam), $clog2(WIDTH), event index width; 5 at default.
- CNTW (localparam), $clog2(DEPTH+1), FIFO occupancy width; 3 at default.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- edge_i  in  WIDTH  sticky edge flags from the upstream stage; a bit stays 1 until the upstream stage is reset.
- evt_valid_o  out  1  FIFO head holds a valid event.
- evt_idx_o  out  IDXW  bit index of the head event; valid only while evt_valid_o=1.
- evt_ready_i  in  1  consumer accepts the head event when evt_valid_o & evt_ready_i.
- pending_o  out  WIDTH  edge_i & ~served; combinational view of bits not yet queued.
- count_o  out  CNTW  FIFO occupancy, 0..DEPTH.
- busy_o  out  1  high when |pending_o or count_o≠0.

Behaviour:
- Reset is asynchronous. While reset is high: served=0, FIFO pointers=0, count=0, evt_valid_o=0, evt_idx_o=0.
  - pending_o and busy_o follow their combinational definitions from edge_i.
  - A reset asserted mid-operation discards queued events. Any bits still set in edge_i afterwards are re-reported.
- served register, WIDTH bits: records bits already pushed into the FIFO.
  - Each cycle: served_next = (served | push_onehot) & edge_i.
  - A bit that drops in edge_i therefore clears its served bit and can fire again on its next assertion.
- Selection:
  - sel = lowest set index of pending_o (priority encoder, bit 0 highest priority).
  - push_onehot = 1<<sel when a push occurs, else 0.
- Push condition: push = |pending_o & (count<DEPTH | pop).
  - Full-with-pop admits the push in the same cycle.
  - At most one push per cycle. Simultaneous new bits drain one per cycle in ascending index order.
- Pop condition: pop = evt_valid_o & evt_ready_i.
- Occupancy update:
  - count_next = count + push − pop.
  - Push+pop in the same cycle leaves count unchanged; this also holds when empty.
- Empty push does not bypass: with count=0, the pushed event appears on the outputs the next cycle.
- FIFO is first-word fall-through:
  - evt_valid_o = (count≠0), registered.
  - evt_idx_o = mem[rd_ptr].
- Pointers wrap modulo DEPTH. Held events are stable while evt_ready_i=0; the bench checks this.
- Latency: edge_i[k] rises before clock edge T with FIFO empty and no lower pending bit → push at T → evt_valid_o=1, evt_idx_o=k after T (1 cycle).
- Backpressure: while count=DEPTH and no pop, pending bits stay in pending_o. No event is ever dropped and no overflow exists.
- Bit k is already queued (served[k]=1) and edge_i[k] is held: k is not re-queued.
- evt_ready_i while evt_valid_o=0: ignored.

Test Plan:
- Reset → evt_valid_o=0, count_o=0, pending_o=edge_i. Then drive edge_i=32'h0000_0010 with evt_ready_i=1 → one cycle later evt_valid_o=1, evt_idx_o=4; after the pop, count_o=0, pending_o=0, busy_o=0.
- Multiple bits, no backpressure: edge_i=32'h8000_0005 in one cycle, evt_ready_i=1 → events 0, 2, 31 on consecutive cycles; each reported exactly once.
- Backpressure/full, DEPTH=4: evt_ready_i=0, edge_i=32'h0000_003F.
  - After 4 cycles: count_o=4, pending_o=32'h30, evt_idx_o held at 0.
  - Raise evt_ready_i → order 0,1,2,3,4,5; count_o stays 4 during push+pop cycles, then drains to 0.
- Re-arm: bit 7 reported; edge_i[7] dropped for one cycle, then reasserted → bit 7 reported a second time. Held assertion without a drop → no repeat.
- Reset mid-operation: count_o=3 with edge_i=32'h0000_0007, pulse reset → FIFO flushed, evt_valid_o=0 immediately (async). After release, events 0,1,2 re-issued.
- Pointer wrap: stream 10 single-bit edges (bits 0..9, one per cycle) with evt_ready_i toggling 1/0 → indices delivered in order 0..9; count_o never exceeds 4.

Source files
------------

// File: rtl/edge_event_queue.sv
// Turns sticky per-bit edge flags into indexed events, lowest index first,
// buffered in a small first-word-fall-through FIFO with a valid/ready output.
module edge_event_queue #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int IDXW  = $clog2(WIDTH),
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  edge_i,
    output logic              evt_valid_o,
    output logic [IDXW-1:0]   evt_idx_o,
    input  logic              evt_ready_i,
    output logic [WIDTH-1:0]  pending_o,
    output logic [CNTW-1:0]   count_o,
    output logic              busy_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] served_r;
    logic [IDXW-1:0]  mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CNTW-1:0]  count_r;
    logic             valid_r;

    logic [WIDTH-1:0] pending_s;
    logic [IDXW-1:0]  sel_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] push_onehot_s;
    logic [CNTW-1:0]  count_next_s;

    // Priority encoder over not-yet-queued bits; scanning downward lets bit 0 win.
    always_comb begin
        sel_s = {IDXW{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            sel_s = pending_s[i] ? IDXW'(i) : sel_s;
        end
    end

    // Handshake, push admission and occupancy bookkeeping.
    always_comb begin
        pending_s     = edge_i & ~served_r;
        pop_s         = valid_r & evt_ready_i;
        push_s        = (|pending_s) & ((count_r < CNTW'(DEPTH)) | pop_s);
        push_onehot_s = {WIDTH{1'b0}};
        if (push_s) begin
            push_onehot_s = {{(WIDTH-1){1'b0}}, 1'b1} << sel_s;
        end else begin
            push_onehot_s = {WIDTH{1'b0}};
        end
        count_next_s  = count_r + CNTW'(push_s) - CNTW'(pop_s);
    end

    // Served mask, FIFO storage, pointers and registered valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            served_r <= {WIDTH{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CNTW{1'b0}};
            valid_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {IDXW{1'b0}};
            end
        end else begin
            // A bit dropping upstream clears its served flag so it can fire again.
            served_r <= (served_r | push_onehot_s) & edge_i;
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != {CNTW{1'b0}});
            if (push_s) begin
                mem_r[wr_ptr_r] <= sel_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
        end
    end

    assign pending_o   = pending_s;
    assign evt_valid_o = valid_r;
    assign evt_idx_o   = mem_r[rd_ptr_r];
    assign count_o     = count_r;
    assign busy_o      = (|pending_s) | (count_r != {CNTW{1'b0}});

endmodule
